// File: rtl/mc_controller.sv
// mc_controller: multicycle sequencing controller for the ARM subset core.
// It steps one instruction through FETCH/DECODE/EXEC/MEM/WB states.
// It drives the datapath select lines and owns the NZCV flag register.
// Optional feature: define MC_CMP_EN to decode CMP (funct[4:1]=1010 with S=1).
// Encoding of Instr (bits 31:12 of the instruction):
//   [19:16] cond, [15:14] op, [13:8] funct, [7:4] rn, [3:0] rd.
module mc_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [19:0]        Instr,
   input  logic [3:0]         ALUFlags,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUControl,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic               RegWrite,
   output logic [1:0]         RegSrc,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   state_t     cur_state;
   state_t     next_state;
   logic [3:0] flags;
   logic [3:0] capture;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       unused_rn;

   logic       cond_ex;
   logic       dp_valid;
   logic       dp_arith;
   logic       dp_writes;
   logic [1:0] dp_alu;
   logic       nz_we;
   logic       cv_we;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign funct     = Instr[13:8];
   assign rd        = Instr[3:0];
   assign unused_rn = ^Instr[7:4];

   // Evaluate the condition field against the stored flags {N,Z,C,V}.
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flags[2];
         4'b0001: cond_ex = ~flags[2];
         4'b0010: cond_ex = flags[1];
         4'b0011: cond_ex = ~flags[1];
         4'b0100: cond_ex = flags[3];
         4'b0101: cond_ex = ~flags[3];
         4'b0110: cond_ex = flags[0];
         4'b0111: cond_ex = ~flags[0];
         4'b1000: cond_ex = flags[1] & ~flags[2];
         4'b1001: cond_ex = ~flags[1] | flags[2];
         4'b1010: cond_ex = (flags[3] == flags[0]);
         4'b1011: cond_ex = (flags[3] != flags[0]);
         4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Decode the data-processing command into an ALU op and writeback/flag class.
   always_comb begin
      dp_valid  = 1'b0;
      dp_arith  = 1'b0;
      dp_writes = 1'b0;
      dp_alu    = 2'b00;
      case (funct[4:1])
         4'b0100: begin dp_valid = 1'b1; dp_arith = 1'b1; dp_writes = 1'b1; dp_alu = 2'b00; end
         4'b0010: begin dp_valid = 1'b1; dp_arith = 1'b1; dp_writes = 1'b1; dp_alu = 2'b01; end
         4'b0000: begin dp_valid = 1'b1; dp_writes = 1'b1; dp_alu = 2'b10; end
         4'b1100: begin dp_valid = 1'b1; dp_writes = 1'b1; dp_alu = 2'b11; end
`ifdef MC_CMP_EN
         4'b1010: begin
            if (funct[0]) begin
               dp_valid = 1'b1;
               dp_arith = 1'b1;
               dp_alu   = 2'b01;
            end
         end
`endif
         default: begin dp_valid = 1'b0; end
      endcase
   end

   // Sequence register; reset abandons whatever instruction was in flight.
   always_ff @(posedge clk) begin
      if (!reset) cur_state <= FETCH;
      else        cur_state <= next_state;
   end

   // Capture ALU flags at the end of EXEC, commit them to NZCV in ALUWB.
   always_ff @(posedge clk) begin
      if (!reset) begin
         flags   <= 4'b0000;
         capture <= 4'b0000;
      end else begin
         if (cur_state == EXECR || cur_state == EXECI) capture <= ALUFlags;
         if (nz_we) flags[3:2] <= capture[3:2];
         if (cv_we) flags[1:0] <= capture[1:0];
      end
   end

   // Next-state and control outputs; every output is forced low while in reset.
   always_comb begin
      next_state = FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      RegWrite   = 1'b0;
      RegSrc     = 2'b00;
      nz_we      = 1'b0;
      cv_we      = 1'b0;
      case (cur_state)
         FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (op)
               2'b00:   next_state = funct[5] ? EXECI : EXECR;
               2'b01:   begin next_state = MEMADR; ImmSrc = 2'b01; RegSrc = 2'b10; end
               2'b10:   begin next_state = BRANCH; ImmSrc = 2'b10; RegSrc = 2'b01; end
               default: next_state = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB    = 2'b01;
            ImmSrc     = 2'b01;
            next_state = funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc     = 1'b1;
            next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = cond_ex;
            next_state = FETCH;
         end
         MEMWR: begin
            AdrSrc     = 1'b1;
            MemWrite   = cond_ex;
            RegSrc     = 2'b10;
            next_state = FETCH;
         end
         EXECR, EXECI: begin
            ALUSrcB    = (cur_state == EXECI) ? 2'b01 : 2'b00;
            ALUControl = dp_valid ? dp_alu : 2'b00;
            next_state = ALUWB;
         end
         ALUWB: begin
            if (rd == 4'hF) PCWrite  = cond_ex & dp_writes;
            else            RegWrite = cond_ex & dp_writes;
            nz_we      = funct[0] & cond_ex & dp_valid;
            cv_we      = funct[0] & cond_ex & dp_valid & dp_arith;
            next_state = FETCH;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b01;
            ImmSrc     = 2'b10;
            ResultSrc  = 2'b10;
            PCWrite    = cond_ex;
            next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase
      if (!reset) begin
         PCWrite    = 1'b0;
         AdrSrc     = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         ResultSrc  = 2'b00;
         ALUControl = 2'b00;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'b00;
         ImmSrc     = 2'b00;
         RegWrite   = 1'b0;
         RegSrc     = 2'b00;
      end
   end

   assign state = reset ? cur_state : FETCH;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller.
// Stimulus pushes one hand-computed control word per cycle.
// A negedge monitor pops each word and compares it with the DUT outputs.
// Word layout: {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//               ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc}.
module tb_mc_controller;

   logic        clk;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        AdrSrc;
   logic        MemWrite;
   logic        IRWrite;
   logic [1:0]  ResultSrc;
   logic [1:0]  ALUControl;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ImmSrc;
   logic        RegWrite;
   logic [1:0]  RegSrc;
   logic [3:0]  state;

   typedef struct {
      logic [19:0] word;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;

   logic [19:0] e_fetch, e_dec_dp, e_dec_mem, e_dec_br;
   logic [19:0] e_memadr, e_memrd, e_memwb_w, e_memwr_0;
   logic [19:0] e_br_0, e_br_1, e_aluwb_w, e_aluwb_0;
   logic        cmp_en;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUControl (ALUControl),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegWrite   (RegWrite),
      .RegSrc     (RegSrc),
      .state      (state)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Build one expected control word from its named fields.
   function automatic logic [19:0] w(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic [1:0] rs,
                                     input logic [1:0] aluc, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] imm, input logic rw, input logic [1:0] rgs);
      return {st, pcw, adr, mw, irw, rs, aluc, asa, asb, imm, rw, rgs};
   endfunction

   // Drive one cycle of inputs just after the edge and queue its expected outputs.
   task automatic applyStimulus(input logic [19:0] instr, input logic rst_n, input logic [3:0] alu_flags,
                                input logic [19:0] exp_word, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      Instr    = instr;
      reset    = rst_n;
      ALUFlags = alu_flags;
      e.word   = exp_word;
      e.name   = name;
      exp_q.push_back(e);
   endtask

   // Compare the DUT outputs with one scoreboard entry.
   task automatic checkOutput(input exp_t e);
      logic [19:0] actual;
      actual = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc};
      checks++;
      if (actual !== e.word) begin
         failures++;
         $display("[TB] FAIL %s actual=%05h required=%05h", e.name, actual, e.word);
      end
   endtask

   // Monitor: mid-cycle, pop any pending expectation and check it.
   always @(negedge clk) begin
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   // Directed instruction sequence.
   initial begin
      int wait_cycles;
`ifdef MC_CMP_EN
      cmp_en = 1'b1;
`else
      cmp_en = 1'b0;
`endif
      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      Instr     = 20'h0;
      ALUFlags  = 4'h0;
      e_fetch   = w(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00);
      e_dec_dp  = w(4'd1, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00);
      e_dec_mem = w(4'd1, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 2'b01, 0, 2'b10);
      e_dec_br  = w(4'd1, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 2'b10, 0, 2'b01);
      e_memadr  = w(4'd2, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b01, 0, 2'b00);
      e_memrd   = w(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00);
      e_memwb_w = w(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00);
      e_memwr_0 = w(4'd5, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 2'b10);
      e_br_0    = w(4'd9, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b01, 2'b10, 0, 2'b00);
      e_br_1    = w(4'd9, 1, 0, 0, 0, 2'b10, 2'b00, 1, 2'b01, 2'b10, 0, 2'b00);
      e_aluwb_w = w(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00);
      e_aluwb_0 = w(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00);

      // Power-on reset: outputs all zero.
      applyStimulus(20'hE2802, 0, 4'h0, 20'h0, "por_0");
      applyStimulus(20'hE2802, 0, 4'h0, 20'h0, "por_1");

      // ADD R2,R0,#5 with S=0: flags must stay 0000.
      applyStimulus(20'hE2802, 1, 4'h0, e_fetch,  "add_fetch");
      applyStimulus(20'hE2802, 1, 4'h0, e_dec_dp, "add_decode");
      applyStimulus(20'hE2802, 1, 4'b0100,
                    w(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00), "add_execi");
      applyStimulus(20'hE2802, 1, 4'h0, e_aluwb_w, "add_aluwb");

      // BEQ after ADD: Z still 0, so no PC write.
      applyStimulus(20'h0A000, 1, 4'h0, e_fetch,  "beq1_fetch");
      applyStimulus(20'h0A000, 1, 4'h0, e_dec_br, "beq1_decode");
      applyStimulus(20'h0A000, 1, 4'h0, e_br_0,   "beq1_branch");

      // SUBS R3,R3,R3: ALU reports Z=1,C=1.
      applyStimulus(20'hE0533, 1, 4'h0, e_fetch,  "subs_fetch");
      applyStimulus(20'hE0533, 1, 4'h0, e_dec_dp, "subs_decode");
      applyStimulus(20'hE0533, 1, 4'b0110,
                    w(4'd6, 0, 0, 0, 0, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00), "subs_execr");
      applyStimulus(20'hE0533, 1, 4'h0, e_aluwb_w, "subs_aluwb");

      // LDREQ R4,[R0,#8]: Z=1 so the load writes back.
      applyStimulus(20'h05904, 1, 4'h0, e_fetch,   "ldreq_fetch");
      applyStimulus(20'h05904, 1, 4'h0, e_dec_mem, "ldreq_decode");
      applyStimulus(20'h05904, 1, 4'h0, e_memadr,  "ldreq_memadr");
      applyStimulus(20'h05904, 1, 4'h0, e_memrd,   "ldreq_memrd");
      applyStimulus(20'h05904, 1, 4'h0, e_memwb_w, "ldreq_memwb");

      // STRNE R4,[R0,#8]: Z=1 so MemWrite stays low.
      applyStimulus(20'h15804, 1, 4'h0, e_fetch,   "strne_fetch");
      applyStimulus(20'h15804, 1, 4'h0, e_dec_mem, "strne_decode");
      applyStimulus(20'h15804, 1, 4'h0, e_memadr,  "strne_memadr");
      applyStimulus(20'h15804, 1, 4'h0, e_memwr_0, "strne_memwr");

      // LDR abandoned by a 3-cycle reset where MEMRD would have been.
      applyStimulus(20'hE5904, 1, 4'h0, e_fetch,   "ldr_fetch");
      applyStimulus(20'hE5904, 1, 4'h0, e_dec_mem, "ldr_decode");
      applyStimulus(20'hE5904, 1, 4'h0, e_memadr,  "ldr_memadr");
      for (int i = 0; i < 3; i++)
         applyStimulus(20'hE5904, 0, 4'h0, 20'h0, $sformatf("midrst_%0d", i));

      // BEQ after reset: flags were cleared, so no PC write.
      applyStimulus(20'h0A000, 1, 4'h0, e_fetch,  "beq2_fetch");
      applyStimulus(20'h0A000, 1, 4'h0, e_dec_br, "beq2_decode");
      applyStimulus(20'h0A000, 1, 4'h0, e_br_0,   "beq2_branch");

      // B (always): PC write in BRANCH.
      applyStimulus(20'hEA000, 1, 4'h0, e_fetch,  "bal_fetch");
      applyStimulus(20'hEA000, 1, 4'h0, e_dec_br, "bal_decode");
      applyStimulus(20'hEA000, 1, 4'h0, e_br_1,   "bal_branch");

      // CMP R1,R1: a compare when enabled, otherwise unimplemented.
      applyStimulus(20'hE1510, 1, 4'h0, e_fetch,  "cmp_fetch");
      applyStimulus(20'hE1510, 1, 4'h0, e_dec_dp, "cmp_decode");
      applyStimulus(20'hE1510, 1, 4'b0110,
                    w(4'd6, 0, 0, 0, 0, 2'b00, cmp_en ? 2'b01 : 2'b00, 0, 2'b00, 2'b00, 0, 2'b00),
                    "cmp_execr");
      applyStimulus(20'hE1510, 1, 4'h0, e_aluwb_0, "cmp_aluwb");
      applyStimulus(20'h0A000, 1, 4'h0, e_fetch,  "beq3_fetch");
      applyStimulus(20'h0A000, 1, 4'h0, e_dec_br, "beq3_decode");
      applyStimulus(20'h0A000, 1, 4'h0, cmp_en ? e_br_1 : e_br_0, "beq3_branch");
      applyStimulus(20'h2A000, 1, 4'h0, e_fetch,  "bcs1_fetch");
      applyStimulus(20'h2A000, 1, 4'h0, e_dec_br, "bcs1_decode");
      applyStimulus(20'h2A000, 1, 4'h0, cmp_en ? e_br_1 : e_br_0, "bcs1_branch");

      // ORRS R5,R5,R5 with ALU flags 1111: only N,Z are written.
      applyStimulus(20'hE1955, 1, 4'h0, e_fetch,  "orrs_fetch");
      applyStimulus(20'hE1955, 1, 4'h0, e_dec_dp, "orrs_decode");
      applyStimulus(20'hE1955, 1, 4'b1111,
                    w(4'd6, 0, 0, 0, 0, 2'b00, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00), "orrs_execr");
      applyStimulus(20'hE1955, 1, 4'h0, e_aluwb_w, "orrs_aluwb");
      applyStimulus(20'h4A000, 1, 4'h0, e_fetch,  "bmi_fetch");
      applyStimulus(20'h4A000, 1, 4'h0, e_dec_br, "bmi_decode");
      applyStimulus(20'h4A000, 1, 4'h0, e_br_1,   "bmi_branch");
      applyStimulus(20'h6A000, 1, 4'h0, e_fetch,  "bvs_fetch");
      applyStimulus(20'h6A000, 1, 4'h0, e_dec_br, "bvs_decode");
      applyStimulus(20'h6A000, 1, 4'h0, e_br_0,   "bvs_branch");
      applyStimulus(20'h2A000, 1, 4'h0, e_fetch,  "bcs2_fetch");
      applyStimulus(20'h2A000, 1, 4'h0, e_dec_br, "bcs2_decode");
      applyStimulus(20'h2A000, 1, 4'h0, cmp_en ? e_br_1 : e_br_0, "bcs2_branch");

      // Drain the scoreboard within a bounded number of cycles.
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
